// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-code converter between N_REQ
// requesters. One request is granted per cycle; the converted value is
// held in a result register with the requester ID until it is consumed.
module gray_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_mode,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W-1:0]       res_data,
    output logic [IDW-1:0]     res_id,
    output logic               res_mode,
    output logic               busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;

    logic             can_accept;
    logic             grant_found;
    logic             grant;
    logic [IDW-1:0]   grant_idx;
    logic [N_REQ-1:0] grant_vec;
    logic [W-1:0]     grant_data;
    logic             grant_mode;
    int               idx;

    // mode 0: binary->Gray, mode 1: Gray->binary; width is preserved
    function automatic logic [W-1:0] gray_conv(input logic [W-1:0] v,
                                               input logic         mode);
        logic [W-1:0] r;
        if (!mode) begin
            r = v ^ (v >> 1);
        end else begin
            r[W-1] = v[W-1];
            for (int j = W - 2; j >= 0; j--) begin
                r[j] = r[j+1] ^ v[j];
            end
        end
        return r;
    endfunction

    // Search requesters starting at ptr and wrapping; first valid one wins
    always_comb begin
        can_accept  = (state == EMPTY) || (res_valid && res_ready);
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        grant_data  = '0;
        grant_mode  = 1'b0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found    = 1'b1;
                grant_idx      = IDW'(idx);
                grant_vec[idx] = 1'b1;
                grant_data     = req_data[idx*W +: W];
                grant_mode     = req_mode[idx];
            end
        end
        // Held off during reset so nothing is accepted while rst_n is low
        grant     = rst_n && can_accept && grant_found;
        req_ready = grant ? grant_vec : '0;
        busy      = res_valid || (|req_valid);
    end

    // Result register, state and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ptr       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_mode  <= 1'b0;
        end else if (grant) begin
            // Refill (possibly draining the previous result on the same edge)
            state     <= FULL;
            res_valid <= 1'b1;
            res_data  <= gray_conv(grant_data, grant_mode);
            res_id    <= grant_idx;
            res_mode  <= grant_mode;
            ptr       <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (res_valid && res_ready) begin
            // Drain only; payload keeps its last value
            state     <= EMPTY;
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed testbench for gray_conv_arbiter with hand-computed expectations.
module tb_gray_conv_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 8;
    localparam int IDW   = 2;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_mode;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               res_valid;
    logic               res_ready;
    logic [W-1:0]       res_data;
    logic [IDW-1:0]     res_id;
    logic               res_mode;
    logic               busy;

    int n_checks;
    int n_fail;

    logic [7:0] exp_gray [4];
    logic [7:0] hold_data;

    gray_conv_arbiter #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_mode  (res_mode),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request from requester r; result checked after the accept edge,
    // then the request is dropped and the result drains on the next edge
    task automatic do_one(input int r, input logic mode, input logic [7:0] data,
                          input logic [7:0] exp, input string tag);
        req_valid         = '0;
        req_valid[r]      = 1'b1;
        req_mode          = '0;
        req_mode[r]       = mode;
        req_data[r*8 +: 8] = data;
        step();
        check({tag, "_data"}, {24'h0, res_data}, {24'h0, exp});
        check({tag, "_id"},   {30'h0, res_id},   r);
        check({tag, "_mode"}, {31'h0, res_mode}, {31'h0, mode});
        req_valid = '0;
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_mode  = '0;
        req_data  = '0;
        res_ready = 1'b0;
        exp_gray[0] = 8'h19;
        exp_gray[1] = 8'h33;
        exp_gray[2] = 8'h2A;
        exp_gray[3] = 8'h66;

        // Reset state
        step();
        step();
        check("rst_res_valid", {31'h0, res_valid}, 0);
        check("rst_res_data",  {24'h0, res_data},  0);
        check("rst_res_id",    {30'h0, res_id},    0);
        check("rst_res_mode",  {31'h0, res_mode},  0);
        check("rst_busy",      {31'h0, busy},      0);
        req_valid = 4'b0001;
        #1;
        check("rst_req_ready", {28'h0, req_ready}, 0);
        rst_n = 1'b1;

        // Test 1: requester 0, binary->Gray of 0x2D
        req_data[7:0] = 8'h2D;
        res_ready = 1'b1;
        #1;
        check("t1_ready", {28'h0, req_ready}, 32'h1);
        step();
        check("t1_valid", {31'h0, res_valid}, 1);
        check("t1_data",  {24'h0, res_data},  32'h3B);
        check("t1_id",    {30'h0, res_id},    0);
        check("t1_mode",  {31'h0, res_mode},  0);
        req_valid = '0;
        step();
        check("t1_drain", {31'h0, res_valid}, 0);
        check("t1_keep_data", {24'h0, res_data}, 32'h3B);

        // Test 2: conversions in both directions via requester 2
        do_one(2, 1'b1, 8'h3B, 8'h2D, "t2_g2b_3b");
        do_one(2, 1'b1, 8'h80, 8'hFF, "t2_g2b_80");
        do_one(2, 1'b0, 8'hFF, 8'h80, "t2_b2g_ff");
        do_one(2, 1'b0, 8'h00, 8'h00, "t2_b2g_00");
        // grant to 3 moves ptr to 0 for the round-robin sweep
        do_one(3, 1'b1, 8'h00, 8'h00, "t2_g2b_00");

        // Test 3: all requesters valid, continuous flow
        req_mode  = '0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t3_valid", {31'h0, res_valid}, 1);
            check("t3_id",    {30'h0, res_id},    i % 4);
            check("t3_data",  {24'h0, res_data},  {24'h0, exp_gray[i % 4]});
        end

        // Test 4: backpressure with requester 1's result held
        res_ready = 1'b0;
        #1;
        check("t4_ready_off", {28'h0, req_ready}, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_valid", {31'h0, res_valid}, 1);
            check("t4_hold_id",    {30'h0, res_id},    1);
            check("t4_hold_data",  {24'h0, res_data},  32'h33);
            check("t4_hold_mode",  {31'h0, res_mode},  0);
            check("t4_hold_ready", {28'h0, req_ready}, 0);
            check("t4_busy",       {31'h0, busy},      1);
        end
        res_ready = 1'b1;
        #1;
        check("t4_ready_on", {28'h0, req_ready}, 32'h4);
        step();
        check("t4_next_id",   {30'h0, res_id},   2);
        check("t4_next_data", {24'h0, res_data}, 32'h2A);
        req_valid = '0;
        step();

        // Test 5: sparse requests
        do_one(1, 1'b0, 8'h00, 8'h00, "t5_g1");
        do_one(3, 1'b0, 8'h02, 8'h03, "t5_g3");
        req_valid = 4'b1010;
        req_data  = {8'h05, 8'h00, 8'h04, 8'h00};
        req_mode  = '0;
        #1;
        check("t5_ready_1", {28'h0, req_ready}, 32'h2);
        step();
        check("t5_id_1",   {30'h0, res_id},   1);
        check("t5_data_1", {24'h0, res_data}, 32'h06);
        req_valid = 4'b1000;
        step();
        check("t5_id_3",   {30'h0, res_id},   3);
        check("t5_data_3", {24'h0, res_data}, 32'h07);
        req_valid = '0;
        step();

        // Test 6: asynchronous reset while FULL
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h2D;
        step();
        check("t6_full", {31'h0, res_valid}, 1);
        res_ready = 1'b0;
        req_valid = 4'b1111;
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'h0, res_valid}, 0);
        check("t6_rst_ready", {28'h0, req_ready}, 0);
        check("t6_rst_data",  {24'h0, res_data},  0);
        step();
        #3;
        rst_n = 1'b1;
        #1;
        check("t6_post_ready", {28'h0, req_ready}, 32'h1);
        hold_data = res_data;
        step();
        check("t6_post_valid", {31'h0, res_valid}, 1);
        check("t6_post_id",    {30'h0, res_id},    0);
        check("t6_post_data",  {24'h0, res_data},  32'h3B);
        check("t6_pre_data",   {24'h0, hold_data}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Round-robin arbiter and sequencer that shares one W-bit Gray-code conversion unit between N_REQ requesters. Each requester asks for binary->Gray or Gray->binary conversion through a valid/ready handshake. The block grants one request per cycle, registers the converted result with the requester ID, and holds it until the downstream consumer accepts it. It sits between the address/counter producers and the consumer of the converted codes.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, data width in bits
IDW, 2, width of res_id; must equal ceil(log2(N_REQ)), minimum 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_mode  in  N_REQ  per-requester mode: 0 = binary->Gray, 1 = Gray->binary
req_data  in  N_REQ*W  per-requester operand; requester i uses bits [i*W +: W]
req_ready  out  N_REQ  one-hot grant; request i is accepted on an edge where req_valid[i] && req_ready[i]
res_valid  out  1  result register holds a valid result
res_ready  in  1  consumer accepts the result
res_data  out  W  converted value
res_id  out  IDW  index of the requester that produced res_data
res_mode  out  1  mode used for res_data
busy  out  1  high when res_valid=1 or any req_valid bit is 1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - res_valid=0, res_data=0, res_id=0, res_mode=0.
  - Round-robin pointer ptr=0; state=EMPTY.
  - req_ready=0 while rst_n=0.
  - An in-flight result is discarded; nothing is replayed.
- State machine, two states:
  - EMPTY (res_valid=0)
  - FULL (res_valid=1)
- Acceptance condition: can_accept = (state==EMPTY) || (res_valid && res_ready).
- Grant (combinational):
  - When can_accept is true, req_ready is one-hot on the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Otherwise req_ready=0.
  - req_ready never depends on res_data.
- On a clock edge with a grant to requester i:
  - res_data <= conv(req_data[i], req_mode[i]).
  - res_id <= i; res_mode <= req_mode[i]; res_valid <= 1; state <= FULL.
  - ptr <= (i+1) mod N_REQ.
- On an edge with res_valid && res_ready and no grant: res_valid <= 0, state <= EMPTY. res_data, res_id and res_mode keep their last values.
- Latency and throughput:
  - Accept edge k -> res_valid=1 after edge k, so the result is visible in the following cycle.
  - With res_ready held at 1, one result is produced per cycle (drain and refill on the same edge).
- Backpressure: while FULL and res_ready=0, res_data, res_id and res_mode are stable and req_ready=0.
- ptr does not advance when no grant occurs.
- Conversion (pure function, W bits, no width growth):
  - Binary->Gray: g = b ^ (b >> 1).
  - Gray->binary: b[W-1] = g[W-1]; b[j] = b[j+1] ^ g[j] for j = W-2 down to 0.
- Requesters must hold req_valid, req_mode and req_data stable until accepted. The arbiter does not latch unaccepted requests.
- Bits of req_data belonging to non-granted requesters have no effect.

Test Plan:
1. Reset, then req_valid=4'b0001, req_data[7:0]=0x2D, mode 0, res_ready=1 -> after the accept edge: res_valid=1, res_data=0x3B, res_id=0, res_mode=0; following cycle res_valid=0.
2. Requester 2, mode 1, data 0x3B, then 0x80 -> res_data=0x2D then 0xFF, res_id=2. Also check binary 0xFF, mode 0 -> 0x80, and 0x00 -> 0x00.
3. All four req_valid held high, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive edges, res_valid continuously 1, res_id sequence matches.
4. FULL with res_ready=0 for 5 cycles while req_valid=4'b1111 -> req_ready=0, and res_data/res_id/res_mode unchanged. Raise res_ready -> drain and next grant on the same edge, to ptr's requester.
5. Sparse requests: only req 3 valid after a grant to requester 1 -> grant 3, ptr becomes 0; next simultaneous req 1 and req 3 -> requester 1 granted first.
6. Drop rst_n mid-cycle while FULL -> res_valid=0 immediately (before the next edge) and req_ready=0. After release with all requests valid -> first grant to requester 0.
